// File: rtl/cycle_timer.sv
// Phase-duration sequencer: times each one-hot washing-machine phase for
// base_T x mode ticks and returns a single-cycle completion strobe.
`timescale 1ns/1ps
module cycle_timer #(
    parameter int CNT_W    = 16,
    parameter int PRESCALE = 4,
    parameter int SOAK_T   = 8,
    parameter int WASH_T   = 12,
    parameter int RINSE_T  = 6,
    parameter int SPIN_T   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode_sel,
    input  logic             mode_load,
    input  logic             soak,
    input  logic             wash,
    input  logic             rinse,
    input  logic             spin,
    input  logic             pause,
    output logic             soaked,
    output logic             washed,
    output logic             rinsed,
    output logic             spun,
    output logic             busy,
    output logic [CNT_W-1:0] remaining,
    output logic             phase_err
);

    localparam int PW = $clog2(PRESCALE);
    localparam logic [PW-1:0]    PRE_MAX  = PW'(PRESCALE - 1);
    localparam logic [PW-1:0]    PRE_ONE  = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t           state_r, state_s;
    logic [1:0]       mode_r;
    logic [PW-1:0]    presc_r, presc_s;
    logic [CNT_W-1:0] count_r, count_s;
    logic [3:0]       active_r, active_s;
    logic [3:0]       strobe_r, strobe_s;
    logic             busy_r, busy_s;
    logic [3:0]       phase_s;
    logic             one_hot_s;

    // Base duration of the requested phase, widened before scaling by mode.
    function automatic logic [CNT_W-1:0] duration(input logic [3:0] ph, input logic [1:0] m);
        logic [CNT_W-1:0] base;
        case (ph)
            4'b0001: base = CNT_W'(SOAK_T);
            4'b0010: base = CNT_W'(WASH_T);
            4'b0100: base = CNT_W'(RINSE_T);
            4'b1000: base = CNT_W'(SPIN_T);
            default: base = CNT_ZERO;
        endcase
        return base * CNT_W'(m);
    endfunction

    assign phase_s   = {spin, rinse, wash, soak};
    assign one_hot_s = (phase_s != 4'd0) && ((phase_s & (phase_s - 4'd1)) == 4'd0);
    assign phase_err = (phase_s != 4'd0) && !one_hot_s;

    // Mode register; a zero selection is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_r <= 2'd1;
        end else if (mode_load && (mode_sel != 2'd0)) begin
            mode_r <= mode_sel;
        end else begin
            mode_r <= mode_r;
        end
    end

    // Next-state, counter and strobe logic.
    always_comb begin
        state_s  = state_r;
        presc_s  = presc_r;
        count_s  = count_r;
        active_s = active_r;
        strobe_s = 4'd0;
        if (!one_hot_s) begin
            // No phase or conflicting phases: abort quietly.
            state_s  = ST_IDLE;
            presc_s  = {PW{1'b0}};
            count_s  = CNT_ZERO;
            active_s = 4'd0;
        end else if (phase_s != active_r) begin
            // A phase change takes priority over any terminal tick.
            state_s  = ST_RUN;
            presc_s  = {PW{1'b0}};
            count_s  = duration(phase_s, mode_r);
            active_s = phase_s;
        end else begin
            case (state_r)
                ST_RUN, ST_PAUSED: begin
                    if (pause) begin
                        state_s = ST_PAUSED;
                    end else if (presc_r == PRE_MAX) begin
                        presc_s = {PW{1'b0}};
                        count_s = count_r - CNT_ONE;
                        if (count_r == CNT_ONE) begin
                            state_s  = ST_DONE;
                            strobe_s = active_r;
                        end else begin
                            state_s  = ST_RUN;
                        end
                    end else begin
                        state_s = ST_RUN;
                        presc_s = presc_r + PRE_ONE;
                    end
                end
                ST_DONE: state_s = ST_DONE;
                ST_IDLE: state_s = ST_IDLE;
                default: state_s = ST_IDLE;
            endcase
        end
        busy_s = (state_s == ST_RUN) || (state_s == ST_PAUSED);
    end

    // Timer state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            presc_r  <= {PW{1'b0}};
            count_r  <= CNT_ZERO;
            active_r <= 4'd0;
            strobe_r <= 4'd0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            presc_r  <= presc_s;
            count_r  <= count_s;
            active_r <= active_s;
            strobe_r <= strobe_s;
            busy_r   <= busy_s;
        end
    end

    assign soaked    = strobe_r[0];
    assign washed    = strobe_r[1];
    assign rinsed    = strobe_r[2];
    assign spun      = strobe_r[3];
    assign busy      = busy_r;
    assign remaining = count_r;

endmodule

// File: doc/cycle_timer.md
Name: cycle_timer

Overview:
- Phase-duration sequencer for the washing-machine controller FSM.
- Watches the FSM's one-hot phase outputs (soak/wash/rinse/spin).
- Times each phase for a duration set by the selected wash mode, then returns the single-cycle completion strobe (soaked/washed/rinsed/spun) that advances the FSM.
- Sits beside the controller FSM; its outputs drive the controller's completion inputs directly.

Parameters:
- CNT_W, 16, width of tick counter and `remaining` output.
- PRESCALE, 4, clock cycles per tick; legal range ≥2.
- SOAK_T, 8, soak base duration in ticks; legal range ≥1.
- WASH_T, 12, wash base duration in ticks; legal range ≥1.
- RINSE_T, 6, rinse base duration in ticks; legal range ≥1.
- SPIN_T, 4, spin base duration in ticks; legal range ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mode_sel  in  2  wash mode 1..3; 0 is illegal.
- mode_load  in  1  latch mode_sel this cycle.
- soak  in  1  FSM phase indicator.
- wash  in  1  FSM phase indicator.
- rinse  in  1  FSM phase indicator.
- spin  in  1  FSM phase indicator.
- pause  in  1  freeze timing (door open / hold).
- soaked  out  1  one-cycle completion strobe.
- washed  out  1  one-cycle completion strobe.
- rinsed  out  1  one-cycle completion strobe.
- spun  out  1  one-cycle completion strobe.
- busy  out  1  high in RUN and PAUSED.
- remaining  out  CNT_W  ticks left in the current phase.
- phase_err  out  1  more than one phase input high.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, mode=1, prescaler=0, count=0, active phase=none.
  - All outputs 0.
- Mode register:
  - Loads mode_sel on any edge where mode_load=1 and mode_sel≠0.
  - mode_sel=0 is ignored and the register holds.
  - A new mode takes effect only at the next phase load; an in-progress count is never rescaled.
- Duration: D = base_T × mode. Widen to CNT_W before multiplying. Requirement: 3×max(base_T) < 2^CNT_W.
- States:
  - IDLE: no phase input is high.
  - RUN: timing the active phase.
  - PAUSED: timing frozen.
  - DONE: strobe issued; waiting for the phase input to change.
- Phase load:
  - Trigger: exactly one phase input high, and it differs from the registered active phase (includes a fresh entry from IDLE or DONE).
  - On edge k: count←D, prescaler←0, active←that phase, state←RUN.
- RUN, on each edge:
  - pause=1: state←PAUSED; prescaler and count hold.
  - Otherwise prescaler increments. When prescaler==PRESCALE-1, it wraps to 0 and count decrements.
  - On the edge where count goes 1→0: state←DONE and the matching strobe is registered high.
- Timing: count reaches 0 at edge k+D×PRESCALE (no pauses). The strobe is high for exactly one cycle after that edge, then low.
- PAUSED: returns to RUN on the first edge with pause=0, resuming from the held values. No ticks are lost or added.
- DONE:
  - Strobe is never repeated.
  - When the FSM moves to the next phase, a fresh load occurs.
  - If all phases go low, state←IDLE.
- Abort:
  - All phase inputs low in RUN or PAUSED (cancel or reset in the FSM): state←IDLE next edge, count←0, no strobe.
  - A different single phase appearing mid-run: immediately reloads for the new phase, no strobe for the old one.
- Multiple phase inputs high:
  - phase_err=1 (combinational from inputs).
  - State←IDLE, count←0, active←none, no strobe.
  - Normal operation resumes when exactly one phase input is high.
- Outputs:
  - remaining = count.
  - busy = (state==RUN or PAUSED).
  - At most one strobe is high in any cycle.
- Simultaneous events:
  - Phase change and terminal tick on the same edge: the phase change wins (reload, no strobe).
  - pause and terminal tick on the same edge: pause wins, no decrement.

Test Plan:
- mode_load with mode_sel=1, then soak held high from edge k → soaked high only in the cycle after edge k+32; remaining reaches 0; state DONE while soak stays high.
- mode_sel=3, then wash → washed after 3×12×4=144 cycles. mode_load with mode_sel=2 mid-wash does not change it. The subsequent rinse times 2×6×4=48 cycles.
- mode 1, spin, pause asserted for 10 cycles mid-count → spun delayed by exactly 10 cycles; remaining is frozen while paused.
- soak running with remaining=5, then soak drops (cancel) → no soaked strobe; busy=0 and remaining=0 the next cycle. A re-entry to soak loads the full 8 ticks again.
- soak and wash high together → phase_err=1, count=0, no strobe; release wash → soak loads 8×mode.
- rst_n pulsed low mid-rinse, asynchronously (not clock-aligned) → all outputs 0 immediately, mode back to 1; the rinse reloads after rst_n rises.
